pe_buffer_manager: RTL and testbench

Buffer manager that sits directly upstream and downstream of one processing element (PE). It fills the task buffer block (TBB) from an input stream, then starts the PE and serves its TBB reads. It captures the PE's writes into the result buffer block (RBB), then drains the RBB to an output stream. Each job is one fill / run / drain pass.

---
 rtl/pe_buffer_manager_if.sv | 24 ++
 rtl/pe_buffer_manager.sv | 157 +++++++++++++++
 tb/tb_pe_buffer_manager.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_buffer_manager_if.sv
// Stream bundle between the buffer manager and its fill source / drain sink.
// master = stream producer/consumer side, slave = buffer manager side.
interface pe_buffer_manager_if #(
    parameter int TBB_DATA_WIDTH = 32,
    parameter int RBB_DATA_WIDTH = 512
);
    logic                      in_valid;
    logic                      in_ready;
    logic [TBB_DATA_WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [RBB_DATA_WIDTH-1:0] out_data;
    logic                      out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pe_buffer_manager.sv
// Buffer manager for one PE: fills the TBB from a stream, runs the PE against it,
// captures PE writes into the RBB, then drains the RBB to an output stream.
module pe_buffer_manager #(
    parameter int TBB_DATA_WIDTH = 32,
    parameter int TBB_ADDR_WIDTH = 16,
    parameter int RBB_DATA_WIDTH = 512,
    parameter int RBB_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      job_start,
    output logic                      busy,
    output logic                      job_done,
    pe_buffer_manager_if.slave        stream,
    output logic                      bm2pe_reset_n,
    output logic                      bm2pe_start,
    input  logic                      pe2bm_done,
    input  logic                      pe2bm_rbbWrEn,
    input  logic [RBB_ADDR_WIDTH-1:0] pe2bm_rbbWrAddr,
    input  logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbWrDin,
    input  logic [TBB_ADDR_WIDTH-1:0] pe2bm_tbbRdAddr,
    output logic [TBB_DATA_WIDTH-1:0] bm2pe_tbbRdDout
);
    localparam int NT = 2 ** TBB_ADDR_WIDTH;
    localparam int NR = 2 ** RBB_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [TBB_DATA_WIDTH-1:0] tbb [NT];
    logic [RBB_DATA_WIDTH-1:0] rbb [NR];

    logic [TBB_ADDR_WIDTH-1:0] fill_cnt;
    logic                      fill_wr;
    logic                      rbb_wr;
    logic                      run_started;
    logic                      out_xfer;

    logic [RBB_ADDR_WIDTH-1:0] rd_ptr;
    logic                      rd_all;
    logic                      rd_issue;
    logic                      rd_pend;
    logic                      rd_last;
    logic [RBB_DATA_WIDTH-1:0] rd_data;
    logic                      skid_valid;
    logic                      skid_last;
    logic [RBB_DATA_WIDTH-1:0] skid_data;
    logic [1:0]                occ;

    assign fill_wr       = (state == FILL) && stream.in_valid;
    assign rbb_wr        = (state == RUN) && pe2bm_rbbWrEn;
    assign out_xfer      = stream.out_valid && stream.out_ready;
    assign bm2pe_reset_n = !reset && (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        busy            = (state != IDLE);
        job_done        = 1'b0;
        stream.in_ready = 1'b0;
        bm2pe_start     = 1'b0;
        case (state)
            IDLE:  if (job_start) state_nxt = FILL;
            FILL: begin
                stream.in_ready = 1'b1;
                if (fill_wr && fill_cnt == '1) state_nxt = RUN;
            end
            RUN: begin
                bm2pe_start = !run_started;
                if (pe2bm_done) state_nxt = DRAIN;
            end
            DRAIN: if (out_xfer && stream.out_last) state_nxt = DONE;
            DONE: begin
                job_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt    <= '0;
            run_started <= 1'b0;
        end else begin
            run_started <= (state == RUN);
            if (state == IDLE && job_start) fill_cnt <= '0;
            else if (fill_wr)               fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Storage arrays carry no reset so they map onto RAM.
    always_ff @(posedge clk) begin
        if (fill_wr) tbb[fill_cnt] <= stream.in_data;
    end

    always_ff @(posedge clk) begin
        if (rbb_wr) rbb[pe2bm_rbbWrAddr] <= pe2bm_rbbWrDin;
    end

    always_ff @(posedge clk) begin
        if (reset)              bm2pe_tbbRdDout <= '0;
        else if (state == RUN)  bm2pe_tbbRdDout <= tbb[pe2bm_tbbRdAddr];
    end

    always_ff @(posedge clk) begin
        if (rd_issue) rd_data <= rbb[rd_ptr];
    end

    // Prefetch credit: output reg + skid + in-flight read never exceed two words.
    assign occ      = 2'(stream.out_valid) + 2'(skid_valid) + 2'(rd_pend);
    assign rd_issue = (state == DRAIN) && !rd_all && (occ <= 2'(out_xfer) + 2'd1);

    always_ff @(posedge clk) begin
        if (reset || state != DRAIN) begin
            rd_ptr           <= '0;
            rd_all           <= 1'b0;
            rd_pend          <= 1'b0;
            rd_last          <= 1'b0;
            skid_valid       <= 1'b0;
            skid_last        <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            if (reset) stream.out_data <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_last <= (rd_ptr == '1);
                if (rd_ptr == '1) rd_all <= 1'b1;
            end
            if (stream.out_valid && !stream.out_ready) begin
                if (rd_pend) begin
                    skid_valid <= 1'b1;
                    skid_data  <= rd_data;
                    skid_last  <= rd_last;
                end
            end else if (skid_valid) begin
                stream.out_valid <= 1'b1;
                stream.out_data  <= skid_data;
                stream.out_last  <= skid_last;
                skid_valid       <= rd_pend;
                skid_data        <= rd_data;
                skid_last        <= rd_last;
            end else begin
                stream.out_valid <= rd_pend;
                stream.out_last  <= rd_pend && rd_last;
                if (rd_pend) stream.out_data <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_pe_buffer_manager.sv
// Randomized scoreboard bench for pe_buffer_manager with a phase-level reference model.
module tb_pe_buffer_manager;
    localparam int TDW = 32;
    localparam int TAW = 4;
    localparam int RDW = 128;
    localparam int RAW = 3;
    localparam int NT  = 16;
    localparam int NR  = 8;

    typedef enum int {M_IDLE, M_FILL, M_RUN, M_DRAIN, M_DONE} mphase_t;
    typedef struct {
        logic [RDW-1:0] data;
        logic           last;
    } oword_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           job_start = 1'b0;
    logic           busy, job_done, bm2pe_reset_n, bm2pe_start;
    logic           pe2bm_done = 1'b0;
    logic           pe2bm_rbbWrEn = 1'b0;
    logic [RAW-1:0] pe2bm_rbbWrAddr = '0;
    logic [RDW-1:0] pe2bm_rbbWrDin = '0;
    logic [TAW-1:0] pe2bm_tbbRdAddr = '0;
    logic [TDW-1:0] bm2pe_tbbRdDout;

    pe_buffer_manager_if #(.TBB_DATA_WIDTH(TDW), .RBB_DATA_WIDTH(RDW)) sif ();

    pe_buffer_manager #(
        .TBB_DATA_WIDTH(TDW),
        .TBB_ADDR_WIDTH(TAW),
        .RBB_DATA_WIDTH(RDW),
        .RBB_ADDR_WIDTH(RAW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .job_start       (job_start),
        .busy            (busy),
        .job_done        (job_done),
        .stream          (sif),
        .bm2pe_reset_n   (bm2pe_reset_n),
        .bm2pe_start     (bm2pe_start),
        .pe2bm_done      (pe2bm_done),
        .pe2bm_rbbWrEn   (pe2bm_rbbWrEn),
        .pe2bm_rbbWrAddr (pe2bm_rbbWrAddr),
        .pe2bm_rbbWrDin  (pe2bm_rbbWrDin),
        .pe2bm_tbbRdAddr (pe2bm_tbbRdAddr),
        .bm2pe_tbbRdDout (bm2pe_tbbRdDout)
    );

    always #5 clk = ~clk;

    // Reference model / scoreboard state (written only by the monitor).
    int             vectors = 0;
    int             miscompares = 0;
    bit             armed = 1'b0;
    mphase_t        m_phase = M_IDLE;
    bit             m_first = 1'b0;
    int             m_fcnt = 0;
    int             m_xfers = 0;
    int             m_drain_cyc = 0;
    int             m_jobs_done = 0;
    int             m_aborts = 0;
    logic [TDW-1:0] m_tbb [NT];
    logic [RDW-1:0] m_rbb [NR];
    oword_t         out_q [$];
    oword_t         mw;
    logic [TDW-1:0] tbb_exp;
    bit             tbb_pend = 1'b0;
    bit             prev_stall = 1'b0;
    logic [RDW-1:0] prev_data;
    logic           prev_last;
    bit             xfer_last;
    bit             tmo_reported = 1'b0;

    // Stimulus configuration (written only by the main process).
    bit             cfg_first, cfg_tie, cfg_bp, cfg_subset, cfg_noise, cfg_rst3;
    logic [95:0]    cfg_tag;
    bit             start_req = 1'b0;
    bit             rst_done;
    bit             tmo_flag = 1'b0;
    int             pe_k = 0;
    int             stall = 0;
    int             drv_seen = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom & 1);
    endfunction

    always @(negedge clk) begin
        xfer_last = 1'b0;
        if (!armed && reset) begin
            armed = 1'b1;
            chkd("rst_out_data", sif.out_data, '0);
            chkd("rst_tbb_dout", RDW'(bm2pe_tbbRdDout), '0);
        end
        if (tmo_flag && !tmo_reported) begin
            tmo_reported = 1'b1;
            chk1("job_completes_in_budget", tmo_flag, 1'b0);
        end
        if (armed) begin
            if (tbb_pend) begin
                chkd("tbb_rd_data", RDW'(bm2pe_tbbRdDout), RDW'(tbb_exp));
                tbb_pend = 1'b0;
            end
            if (prev_stall) begin
                chk1("stall_valid", sif.out_valid, 1'b1);
                chkd("stall_data", sif.out_data, prev_data);
                chk1("stall_last", sif.out_last, prev_last);
            end
            chk1("busy", busy, m_phase != M_IDLE);
            chk1("in_ready", sif.in_ready, m_phase == M_FILL);
            chk1("job_done", job_done, m_phase == M_DONE);
            chk1("pe_reset_n", bm2pe_reset_n, m_phase == M_RUN && !reset);
            chk1("pe_start", bm2pe_start, m_phase == M_RUN && m_first);
            if (m_phase != M_DRAIN)
                chk1("out_valid_outside_drain", sif.out_valid, 1'b0);
            else if (cfg_tie && m_drain_cyc >= 2)
                chk1("drain_stream_valid", sif.out_valid, 1'b1);

            if (!reset && m_phase == M_DRAIN && sif.out_valid && sif.out_ready) begin
                if (out_q.size() == 0) begin
                    chk1("drain_extra_word", sif.out_valid, 1'b0);
                end else begin
                    mw = out_q.pop_front();
                    chkd("drain_data", sif.out_data, mw.data);
                    chk1("drain_last", sif.out_last, mw.last);
                    xfer_last = mw.last;
                    m_xfers++;
                end
            end
            prev_stall = !reset && m_phase == M_DRAIN && sif.out_valid && !sif.out_ready;
            prev_data  = sif.out_data;
            prev_last  = sif.out_last;

            if (reset) begin
                if (m_phase != M_IDLE) m_aborts++;
                m_phase = M_IDLE;
                m_first = 1'b0;
                out_q.delete();
                tbb_pend   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                case (m_phase)
                    M_IDLE: if (job_start) begin
                        m_phase = M_FILL;
                        m_fcnt  = 0;
                        m_xfers = 0;
                    end
                    M_FILL: if (sif.in_valid) begin
                        m_tbb[m_fcnt] = sif.in_data;
                        if (m_fcnt == NT - 1) begin
                            m_phase = M_RUN;
                            m_first = 1'b1;
                        end
                        m_fcnt++;
                    end
                    M_RUN: begin
                        m_first  = 1'b0;
                        tbb_exp  = m_tbb[pe2bm_tbbRdAddr];
                        tbb_pend = 1'b1;
                        if (pe2bm_rbbWrEn) m_rbb[pe2bm_rbbWrAddr] = pe2bm_rbbWrDin;
                        if (pe2bm_done) begin
                            for (int i = 0; i < NR; i++) begin
                                mw.data = m_rbb[i];
                                mw.last = (i == NR - 1);
                                out_q.push_back(mw);
                            end
                            m_phase     = M_DRAIN;
                            m_drain_cyc = 0;
                        end
                    end
                    M_DRAIN: begin
                        m_drain_cyc++;
                        if (xfer_last) m_phase = M_DONE;
                    end
                    M_DONE: begin
                        m_phase = M_IDLE;
                        m_jobs_done++;
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (m_phase == M_IDLE) begin
            job_start = start_req;
            start_req = 1'b0;
        end else begin
            job_start = cfg_noise ? rbit() : 1'b0;
        end
        sif.in_valid    = cfg_noise ? rbit() : 1'b0;
        sif.in_data     = $urandom;
        pe2bm_rbbWrEn   = cfg_noise ? rbit() : 1'b0;
        pe2bm_rbbWrAddr = RAW'($urandom);
        pe2bm_rbbWrDin  = {$urandom, $urandom, $urandom, $urandom};
        pe2bm_done      = cfg_noise ? rbit() : 1'b0;
        pe2bm_tbbRdAddr = TAW'($urandom);
        sif.out_ready   = cfg_noise ? rbit() : 1'b1;
        if (m_phase != M_RUN) pe_k = 0;
        case (m_phase)
            M_FILL: begin
                sif.in_valid = cfg_bp ? rbit() : 1'b1;
                if (cfg_first) sif.in_data = 32'h100 + 32'(m_fcnt);
            end
            M_RUN: begin
                if (cfg_bp && ($urandom % 3) == 0) begin
                    pe2bm_rbbWrEn = 1'b0;
                    pe2bm_done    = 1'b0;
                end else begin
                    pe2bm_rbbWrAddr = RAW'(pe_k);
                    pe2bm_rbbWrEn   = (pe_k == NR - 1) || !cfg_subset || rbit();
                    pe2bm_rbbWrDin  = {cfg_tag, 32'hdeadbeef + 32'(pe_k)};
                    pe2bm_done      = (pe_k == NR - 1);
                    pe_k++;
                end
            end
            M_DRAIN: begin
                if (m_xfers != drv_seen) begin
                    drv_seen = m_xfers;
                    if (cfg_bp && (m_xfers % 2) == 0) stall = 3;
                end
                sif.out_ready = cfg_tie || (stall == 0 && (cfg_bp || rbit()));
                if (stall > 0) stall--;
                if (cfg_rst3 && !rst_done && m_xfers >= 3) begin
                    reset    = 1'b1;
                    rst_done = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        int jd0, ab0, n;
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b0;
        cfg_first = 1'b0; cfg_tie = 1'b1; cfg_bp = 1'b0;
        cfg_subset = 1'b0; cfg_noise = 1'b0; cfg_rst3 = 1'b0; cfg_tag = '0;
        repeat (2) @(posedge clk);
        for (int j = 0; j < 10; j++) begin
            cfg_first = 1'b0; cfg_tie = 1'b0; cfg_bp = 1'b0;
            cfg_subset = 1'b0; cfg_noise = 1'b0; cfg_rst3 = 1'b0;
            cfg_tag = 96'(j);
            case (j)
                0: begin cfg_first = 1'b1; cfg_tie = 1'b1; end
                1: begin cfg_bp = 1'b1; cfg_subset = 1'b1; cfg_noise = 1'b1; end
                2: begin cfg_rst3 = 1'b1; cfg_tie = 1'b1; cfg_noise = 1'b1; end
                3: begin cfg_tie = 1'b1; cfg_tag = {$urandom, $urandom, $urandom}; end
                default: begin
                    cfg_bp     = rbit();
                    cfg_tie    = !cfg_bp && rbit();
                    cfg_subset = rbit();
                    cfg_noise  = rbit();
                    cfg_tag    = {$urandom, $urandom, $urandom};
                end
            endcase
            rst_done = 1'b0;
            drv_seen = 0;
            stall    = 0;
            repeat ((j == 0) ? 0 : int'($urandom % 4)) drive_cycle();
            jd0 = m_jobs_done;
            ab0 = m_aborts;
            start_req = 1'b1;
            n = 0;
            while (m_jobs_done == jd0 && m_aborts == ab0 && n < 800) begin
                drive_cycle();
                n++;
            end
            if (n >= 800) tmo_flag = 1'b1;
        end
        repeat (4) drive_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
